instr_fetch_queue: RTL and testbench

Fetch stage between `program_counter` and decode. Issues one instruction-memory read per accepted PC over a req/gnt/rvalid handshake and buffers returned instructions with their PC in a small FIFO. Presents them to decode under valid/ready. Pulses `pc_advance` so the PC stage steps only when a fetch is accepted, and discards in-flight data on a control-flow redirect.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/instr_fetch_queue.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch queue.
//   fetch_state_t : request FSM state (IDLE / WAIT / DRAIN)
//   NOP_INST      : instruction substituted for a misaligned fetch
//   fetch_entry_t : queue entry layout {pc, inst, fault} at the default width.
//                   The queue itself stores the same fields flattened so that
//                   XLEN can be overridden.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no fetch outstanding
        ST_WAIT  = 2'd1,   // one fetch outstanding, response will be kept
        ST_DRAIN = 2'd2    // one fetch outstanding, response will be dropped
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
        logic                  fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched entries. Storage is a register array
// so the head is available the cycle after a push (no bypass path).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : empties the FIFO; overrides push/pop in the same cycle
//   push, push_data : write an entry (ignored when full and not popping)
//   pop             : remove head (ignored when empty)
//   head_data       : current head entry
//   count           : number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW:0]    count_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];

    logic do_pop;
    logic do_push;

    assign do_pop  = pop && (count_reg != '0);
    // A full FIFO can still accept a push when the head leaves the same cycle.
    assign do_push = push && ((count_reg != DEPTH_C) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && !flush && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
// Fetch stage between the program counter and decode. Issues one instruction
// memory read per accepted PC (req/gnt/rvalid, at most one outstanding),
// queues returned words with their PC, and hands them to decode under
// valid/ready. Redirect flushes the queue and discards any in-flight response.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   pc_in                    : current PC from the PC stage
//   redirect                 : taken branch/jump; flush everything
//   pc_advance               : PC stage may step (request granted this cycle)
//   imem_req/addr/gnt        : request channel to instruction memory
//   imem_rvalid/rdata        : response channel
//   inst_valid/ready         : handshake to decode
//   inst_out/pc/fault        : head entry; fault marks a misaligned PC (NOP)
// -----------------------------------------------------------------------------
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            redirect,
    output logic            pc_advance,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * XLEN + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_t    state_reg;
    fetch_state_t    state_next;
    logic [XLEN-1:0] req_pc_reg;
    logic            fault_hold_reg;

    logic [CW-1:0]   count;
    logic [EW-1:0]   push_data;
    logic [EW-1:0]   head_data;
    logic            push;
    logic            pop;

    logic            pc_aligned;
    logic [CW:0]     occupancy;
    logic            has_credit;
    logic            resp;
    logic            drain_resp;
    logic            issue_slot;
    logic            fault_push;

    assign pc_aligned = (pc_in[1:0] == 2'b00);

    // Queue slots already spoken for: held entries plus a response we will keep.
    assign occupancy  = {1'b0, count} + {{CW{1'b0}}, (state_reg == ST_WAIT)};
    assign has_credit = (occupancy < DEPTH_C);

    assign resp       = imem_rvalid && (state_reg == ST_WAIT);
    assign drain_resp = imem_rvalid && (state_reg == ST_DRAIN);

    // A new request may go out only when nothing is outstanding, or when the
    // single outstanding response completes this very cycle.
    assign issue_slot = (state_reg == ST_IDLE) || resp || drain_resp;

    // When the outstanding response lands in a queue with no spare slot, a
    // simultaneous pop still leaves room for the next one.
    assign imem_req = !rst && !redirect && pc_aligned && issue_slot
                   && (has_credit || (resp && pop));

    assign imem_addr  = pc_in;
    assign pc_advance = imem_req && imem_gnt;

    // A misaligned PC produces a single faulting NOP and then stalls (the PC
    // does not advance) until a redirect supplies a new target.
    assign fault_push = !rst && !redirect && (state_reg == ST_IDLE)
                     && !pc_aligned && has_credit && !fault_hold_reg;

    assign push      = resp || fault_push;
    assign push_data = resp ? {req_pc_reg, imem_rdata, 1'b0}
                            : {pc_in, XLEN'(NOP_INST), 1'b1};

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;

    assign inst_pc    = head_data[EW-1 -: XLEN];
    assign inst_out   = head_data[XLEN:1];
    assign inst_fault = head_data[0];

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pc_advance) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    // Response arriving with the redirect needs no draining.
                    state_next = imem_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (imem_rvalid) begin
                    state_next = pc_advance ? ST_WAIT : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) begin
                    state_next = pc_advance ? ST_WAIT : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            req_pc_reg     <= '0;
            fault_hold_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (pc_advance) begin
                req_pc_reg <= pc_in;
            end
            if (redirect) begin
                fault_hold_reg <= 1'b0;
            end else if (fault_push) begin
                fault_hold_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
// Directed bench for instr_fetch_queue (DEPTH=2, XLEN=32). Inputs change on
// the falling edge; outputs are compared 1ns later, so combinational outputs
// reflect that cycle's inputs and registered outputs the state after the last
// rising edge.
// Vector row fields:
//   ctl = {rst, redirect, imem_gnt, imem_rvalid, inst_ready}
//   ex  = {imem_req, pc_advance, inst_valid, inst_fault}
//   e_pc/e_out are compared only when inst_valid is expected.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        redirect = 1'b0;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_fault;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [4:0]  ctl;
        logic [31:0] pc;
        logic [31:0] rd;
        logic [3:0]  ex;
        logic [31:0] e_pc;
        logic [31:0] e_out;
    } vec_t;

    instr_fetch_queue #(.DEPTH(2), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .redirect    (redirect),
        .pc_advance  (pc_advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .inst_fault  (inst_fault)
    );

    always #5 clk = ~clk;

    // Memory word returned for a given address.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst         = v.ctl[4];
        redirect    = v.ctl[3];
        imem_gnt    = v.ctl[2];
        imem_rvalid = v.ctl[1];
        inst_ready  = v.ctl[0];
        pc_in       = v.pc;
        imem_rdata  = v.rd;
        #1;
    endtask

    task automatic test_reset();
        vec_t v [4];
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset inst_valid: got %0b want 0", inst_valid); else n_pass++;
        n_checks++; if (inst_out !== 32'h0) $display("FAIL reset inst_out: got %h want 0", inst_out); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0) $display("FAIL reset inst_pc: got %h want 0", inst_pc); else n_pass++;
        n_checks++; if (inst_fault !== 1'b0) $display("FAIL reset inst_fault: got %0b want 0", inst_fault); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset imem_req: got %0b want 0", imem_req); else n_pass++;
        n_checks++; if (pc_advance !== 1'b0) $display("FAIL reset pc_advance: got %0b want 0", pc_advance); else n_pass++;
        // grant, reset while waiting, then a stray response that must be ignored
        v[0] = '{5'b00100, 32'h100, 32'h0,    4'b1100, 32'h0, 32'h0};
        v[1] = '{5'b10100, 32'h100, 32'h0,    4'b0000, 32'h0, 32'h0};
        v[2] = '{5'b00010, 32'h100, 32'h1111, 4'b1000, 32'h0, 32'h0};
        v[3] = '{5'b00000, 32'h100, 32'h0,    4'b1000, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            drive(v[i]);
            n_checks++; if (imem_req !== v[i].ex[3]) $display("FAIL rst_wait[%0d] imem_req: got %0b want %0b", i, imem_req, v[i].ex[3]); else n_pass++;
            n_checks++; if (pc_advance !== v[i].ex[2]) $display("FAIL rst_wait[%0d] pc_advance: got %0b want %0b", i, pc_advance, v[i].ex[2]); else n_pass++;
            n_checks++; if (inst_valid !== v[i].ex[1]) $display("FAIL rst_wait[%0d] inst_valid: got %0b want %0b", i, inst_valid, v[i].ex[1]); else n_pass++;
            if (i == 2) begin
                n_checks++; if (inst_out !== 32'h0) $display("FAIL rst_wait inst_out: got %h want 0", inst_out); else n_pass++;
                n_checks++; if (inst_pc !== 32'h0) $display("FAIL rst_wait inst_pc: got %h want 0", inst_pc); else n_pass++;
            end
            $display("rst_wait[%0d] req=%0b adv=%0b valid=%0b", i, imem_req, pc_advance, inst_valid);
        end
    endtask

    task automatic test_stream();
        vec_t v [6];
        v[0] = '{5'b00101, 32'h0, 32'h0,         4'b1100, 32'h0, 32'h0};
        v[1] = '{5'b00111, 32'h4, mdata(32'h0),  4'b1100, 32'h0, 32'h0};
        v[2] = '{5'b00111, 32'h8, mdata(32'h4),  4'b1110, 32'h0, mdata(32'h0)};
        v[3] = '{5'b00011, 32'hC, mdata(32'h8),  4'b1010, 32'h4, mdata(32'h4)};
        v[4] = '{5'b00001, 32'hC, 32'h0,         4'b1010, 32'h8, mdata(32'h8)};
        v[5] = '{5'b00001, 32'hC, 32'h0,         4'b1000, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            drive(v[i]);
            n_checks++; if (imem_req !== v[i].ex[3]) $display("FAIL stream[%0d] imem_req: got %0b want %0b", i, imem_req, v[i].ex[3]); else n_pass++;
            n_checks++; if (pc_advance !== v[i].ex[2]) $display("FAIL stream[%0d] pc_advance: got %0b want %0b", i, pc_advance, v[i].ex[2]); else n_pass++;
            n_checks++; if (inst_valid !== v[i].ex[1]) $display("FAIL stream[%0d] inst_valid: got %0b want %0b", i, inst_valid, v[i].ex[1]); else n_pass++;
            if (v[i].ex[3]) begin
                n_checks++; if (imem_addr !== v[i].pc) $display("FAIL stream[%0d] imem_addr: got %h want %h", i, imem_addr, v[i].pc); else n_pass++;
            end
            if (v[i].ex[1]) begin
                n_checks++; if (inst_pc !== v[i].e_pc) $display("FAIL stream[%0d] inst_pc: got %h want %h", i, inst_pc, v[i].e_pc); else n_pass++;
                n_checks++; if (inst_out !== v[i].e_out) $display("FAIL stream[%0d] inst_out: got %h want %h", i, inst_out, v[i].e_out); else n_pass++;
                n_checks++; if (inst_fault !== v[i].ex[0]) $display("FAIL stream[%0d] inst_fault: got %0b want %0b", i, inst_fault, v[i].ex[0]); else n_pass++;
            end
            $display("stream[%0d] req=%0b adv=%0b valid=%0b pc=%h inst=%h", i, imem_req, pc_advance, inst_valid, inst_pc, inst_out);
        end
    endtask

    task automatic test_backpressure();
        vec_t v [11];
        v[0]  = '{5'b00100, 32'h20, 32'h0,          4'b1100, 32'h0,  32'h0};
        v[1]  = '{5'b00110, 32'h24, mdata(32'h20),  4'b1100, 32'h0,  32'h0};
        v[2]  = '{5'b00110, 32'h28, mdata(32'h24),  4'b0010, 32'h20, mdata(32'h20)};
        v[3]  = '{5'b00100, 32'h28, 32'h0,          4'b0010, 32'h20, mdata(32'h20)};
        v[4]  = '{5'b00101, 32'h28, 32'h0,          4'b0010, 32'h20, mdata(32'h20)};
        v[5]  = '{5'b00100, 32'h28, 32'h0,          4'b1110, 32'h24, mdata(32'h24)};
        v[6]  = '{5'b00100, 32'h2C, 32'h0,          4'b0010, 32'h24, mdata(32'h24)};
        v[7]  = '{5'b00110, 32'h2C, mdata(32'h28),  4'b0010, 32'h24, mdata(32'h24)};
        v[8]  = '{5'b00001, 32'h2C, 32'h0,          4'b0010, 32'h24, mdata(32'h24)};
        v[9]  = '{5'b00001, 32'h2C, 32'h0,          4'b1010, 32'h28, mdata(32'h28)};
        v[10] = '{5'b00000, 32'h2C, 32'h0,          4'b1000, 32'h0,  32'h0};
        for (int i = 0; i < 11; i++) begin
            drive(v[i]);
            n_checks++; if (imem_req !== v[i].ex[3]) $display("FAIL backpr[%0d] imem_req: got %0b want %0b", i, imem_req, v[i].ex[3]); else n_pass++;
            n_checks++; if (pc_advance !== v[i].ex[2]) $display("FAIL backpr[%0d] pc_advance: got %0b want %0b", i, pc_advance, v[i].ex[2]); else n_pass++;
            n_checks++; if (inst_valid !== v[i].ex[1]) $display("FAIL backpr[%0d] inst_valid: got %0b want %0b", i, inst_valid, v[i].ex[1]); else n_pass++;
            if (v[i].ex[1]) begin
                n_checks++; if (inst_pc !== v[i].e_pc) $display("FAIL backpr[%0d] inst_pc: got %h want %h", i, inst_pc, v[i].e_pc); else n_pass++;
                n_checks++; if (inst_out !== v[i].e_out) $display("FAIL backpr[%0d] inst_out: got %h want %h", i, inst_out, v[i].e_out); else n_pass++;
            end
            $display("backpr[%0d] req=%0b adv=%0b valid=%0b pc=%h", i, imem_req, pc_advance, inst_valid, inst_pc);
        end
    endtask

    task automatic test_redirect();
        vec_t v [10];
        v[0] = '{5'b00101, 32'h10, 32'h0,         4'b1100, 32'h0,  32'h0};
        v[1] = '{5'b01101, 32'h10, 32'h0,         4'b0000, 32'h0,  32'h0};
        v[2] = '{5'b00101, 32'h40, 32'h0,         4'b0000, 32'h0,  32'h0};
        v[3] = '{5'b00111, 32'h40, 32'hDEADBEEF,  4'b1100, 32'h0,  32'h0};
        v[4] = '{5'b00011, 32'h44, 32'h55,        4'b1000, 32'h0,  32'h0};
        v[5] = '{5'b00001, 32'h44, 32'h0,         4'b1010, 32'h40, 32'h55};
        v[6] = '{5'b00100, 32'h80, 32'h0,         4'b1100, 32'h0,  32'h0};
        v[7] = '{5'b00010, 32'h84, 32'hA0,        4'b1000, 32'h0,  32'h0};
        v[8] = '{5'b01100, 32'h84, 32'h0,         4'b0010, 32'h80, 32'hA0};
        v[9] = '{5'b00000, 32'h84, 32'h0,         4'b1000, 32'h0,  32'h0};
        for (int i = 0; i < 10; i++) begin
            drive(v[i]);
            n_checks++; if (imem_req !== v[i].ex[3]) $display("FAIL redirect[%0d] imem_req: got %0b want %0b", i, imem_req, v[i].ex[3]); else n_pass++;
            n_checks++; if (pc_advance !== v[i].ex[2]) $display("FAIL redirect[%0d] pc_advance: got %0b want %0b", i, pc_advance, v[i].ex[2]); else n_pass++;
            n_checks++; if (inst_valid !== v[i].ex[1]) $display("FAIL redirect[%0d] inst_valid: got %0b want %0b", i, inst_valid, v[i].ex[1]); else n_pass++;
            if (v[i].ex[3]) begin
                n_checks++; if (imem_addr !== v[i].pc) $display("FAIL redirect[%0d] imem_addr: got %h want %h", i, imem_addr, v[i].pc); else n_pass++;
            end
            if (v[i].ex[1]) begin
                n_checks++; if (inst_pc !== v[i].e_pc) $display("FAIL redirect[%0d] inst_pc: got %h want %h", i, inst_pc, v[i].e_pc); else n_pass++;
                n_checks++; if (inst_out !== v[i].e_out) $display("FAIL redirect[%0d] inst_out: got %h want %h", i, inst_out, v[i].e_out); else n_pass++;
            end
            $display("redirect[%0d] req=%0b adv=%0b valid=%0b inst=%h", i, imem_req, pc_advance, inst_valid, inst_out);
        end
    endtask

    task automatic test_fault();
        vec_t v [4];
        v[0] = '{5'b00100, 32'h6, 32'h0, 4'b0000, 32'h0, 32'h0};
        v[1] = '{5'b00100, 32'h6, 32'h0, 4'b0011, 32'h6, 32'h13};
        v[2] = '{5'b01100, 32'h6, 32'h0, 4'b0011, 32'h6, 32'h13};
        v[3] = '{5'b00000, 32'h0, 32'h0, 4'b1000, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            drive(v[i]);
            n_checks++; if (imem_req !== v[i].ex[3]) $display("FAIL fault[%0d] imem_req: got %0b want %0b", i, imem_req, v[i].ex[3]); else n_pass++;
            n_checks++; if (pc_advance !== v[i].ex[2]) $display("FAIL fault[%0d] pc_advance: got %0b want %0b", i, pc_advance, v[i].ex[2]); else n_pass++;
            n_checks++; if (inst_valid !== v[i].ex[1]) $display("FAIL fault[%0d] inst_valid: got %0b want %0b", i, inst_valid, v[i].ex[1]); else n_pass++;
            if (v[i].ex[1]) begin
                n_checks++; if (inst_pc !== v[i].e_pc) $display("FAIL fault[%0d] inst_pc: got %h want %h", i, inst_pc, v[i].e_pc); else n_pass++;
                n_checks++; if (inst_out !== v[i].e_out) $display("FAIL fault[%0d] inst_out: got %h want %h", i, inst_out, v[i].e_out); else n_pass++;
                n_checks++; if (inst_fault !== v[i].ex[0]) $display("FAIL fault[%0d] inst_fault: got %0b want %0b", i, inst_fault, v[i].ex[0]); else n_pass++;
            end
            $display("fault[%0d] req=%0b valid=%0b fault=%0b pc=%h inst=%h", i, imem_req, inst_valid, inst_fault, inst_pc, inst_out);
        end
    endtask

    // Queue held at one entry while a response is pushed and the head popped
    // every cycle; ten iterations wrap the 2-entry pointers several times.
    task automatic test_back_to_back();
        vec_t v;
        logic [31:0] a;
        v = '{5'b00100, 32'h200, 32'h0, 4'b0, 32'h0, 32'h0};
        drive(v);
        n_checks++; if (pc_advance !== 1'b1) $display("FAIL b2b first grant pc_advance: got %0b want 1", pc_advance); else n_pass++;
        v = '{5'b00110, 32'h204, mdata(32'h200), 4'b0, 32'h0, 32'h0};
        drive(v);
        n_checks++; if (pc_advance !== 1'b1) $display("FAIL b2b second grant pc_advance: got %0b want 1", pc_advance); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            a = 32'h200 + 32'(4 * i);
            v = '{5'b00111, a + 32'h8, mdata(a + 32'h4), 4'b0, 32'h0, 32'h0};
            drive(v);
            n_checks++; if (inst_valid !== 1'b1) $display("FAIL b2b[%0d] inst_valid: got %0b want 1", i, inst_valid); else n_pass++;
            n_checks++; if (inst_pc !== a) $display("FAIL b2b[%0d] inst_pc: got %h want %h", i, inst_pc, a); else n_pass++;
            n_checks++; if (inst_out !== mdata(a)) $display("FAIL b2b[%0d] inst_out: got %h want %h", i, inst_out, mdata(a)); else n_pass++;
            n_checks++; if (pc_advance !== 1'b1) $display("FAIL b2b[%0d] pc_advance: got %0b want 1", i, pc_advance); else n_pass++;
            $display("b2b[%0d] valid=%0b pc=%h inst=%h adv=%0b", i, inst_valid, inst_pc, inst_out, pc_advance);
        end
        v = '{5'b00011, 32'h230, mdata(32'h22C), 4'b0, 32'h0, 32'h0};
        drive(v);
        n_checks++; if (inst_pc !== 32'h228) $display("FAIL b2b tail0 inst_pc: got %h want 00000228", inst_pc); else n_pass++;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL b2b tail0 imem_req: got %0b want 1", imem_req); else n_pass++;
        v = '{5'b00001, 32'h230, 32'h0, 4'b0, 32'h0, 32'h0};
        drive(v);
        n_checks++; if (inst_pc !== 32'h22C) $display("FAIL b2b tail1 inst_pc: got %h want 0000022c", inst_pc); else n_pass++;
        n_checks++; if (inst_out !== mdata(32'h22C)) $display("FAIL b2b tail1 inst_out: got %h want %h", inst_out, mdata(32'h22C)); else n_pass++;
        v = '{5'b00000, 32'h230, 32'h0, 4'b0, 32'h0, 32'h0};
        drive(v);
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL b2b tail2 inst_valid: got %0b want 0", inst_valid); else n_pass++;
        $display("b2b tail valid=%0b", inst_valid);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
